// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V pipeline front end.
//   XLEN        : datapath width
//   NOP_INSTR   : canonical bubble instruction, addi x0,x0,0
//   ifu_state_t : fetch unit states FETCH / HOLD / FLUSH
//   alignWord   : forces bits [1:0] of an address to zero
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      FLUSH
   } ifu_state_t;

   // Targets come from the ALU unmasked, so the low two bits are cleared here.
   function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
      return addr & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Instruction memory read bus with a busy-wait handshake. A read completes
// in any cycle where i_mem_read=1 and i_mem_busy=0.
//   i_mem_read     : read request            (fetch unit -> memory)
//   i_mem_address  : word address            (fetch unit -> memory)
//   i_mem_readdata : read data               (memory -> fetch unit)
//   i_mem_busy     : memory not ready yet    (memory -> fetch unit)
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
   import riscv_pkg::*;

   logic            i_mem_read;
   logic [XLEN-1:0] i_mem_address;
   logic [XLEN-1:0] i_mem_readdata;
   logic            i_mem_busy;

   modport master (
      output i_mem_read,
      output i_mem_address,
      input  i_mem_readdata,
      input  i_mem_busy
   );

   modport slave (
      input  i_mem_read,
      input  i_mem_address,
      output i_mem_readdata,
      output i_mem_busy
   );

endinterface

// File: rtl/if_id_register.sv
// ---------------------------------------------------------------------------
// if_id_register
// Pipeline register between fetch and decode. Bubble insertion wins over a
// load; with neither, the contents are held.
//   clk, reset       : rising-edge clock, asynchronous active-low reset
//   i_load           : capture i_instruction / i_pc as a valid instruction
//   i_bubble         : replace the instruction with a NOP and clear valid
//   i_instruction    : instruction word to capture
//   i_pc             : PC of that instruction
//   o_instruction    : registered instruction
//   o_pc             : registered PC
//   o_pcPlus4        : registered PC + 4 (link value)
//   o_valid          : register holds a real instruction
// ---------------------------------------------------------------------------
module if_id_register
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            i_load,
   input  logic            i_bubble,
   input  logic [XLEN-1:0] i_instruction,
   input  logic [XLEN-1:0] i_pc,
   output logic [XLEN-1:0] o_instruction,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pcPlus4,
   output logic            o_valid
);

   // A bubble leaves the PC fields alone so decode still sees the last PC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_instruction <= NOP_INSTR;
         o_pc          <= '0;
         o_pcPlus4     <= XLEN'(4);
         o_valid       <= 1'b0;
      end else if (i_bubble) begin
         o_instruction <= NOP_INSTR;
         o_valid       <= 1'b0;
      end else if (i_load) begin
         o_instruction <= i_instruction;
         o_pc          <= i_pc;
         o_pcPlus4     <= i_pc + XLEN'(4);
         o_valid       <= 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Pipeline front end: owns the PC, fetches one word per cycle from the
// instruction memory and fills the IF/ID register. Handles decode stalls,
// memory wait states and branch/jump redirects from execute.
//   RESET_PC           : PC loaded on reset
//   clk, reset         : rising-edge clock, asynchronous active-low reset
//   imem               : instruction memory bus (master side)
//   stall              : decode not accepting; hold PC and IF/ID
//   branch_jump_taken  : redirect request from execute
//   branch_jump_target : redirect PC (bits [1:0] ignored)
//   instruction        : IF/ID instruction (NOP when not valid)
//   pc_out, pc_plus_4  : PC of instruction and PC + 4
//   valid              : IF/ID holds a real instruction
// Build option IFU_SKID_BUFFER_EN: keep a word that completed under stall
// in a one-entry buffer instead of refetching it after the stall.
// ---------------------------------------------------------------------------
module instruction_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       reset,
   instruction_fetch_unit_if.master   imem,
   input  logic                       stall,
   input  logic                       branch_jump_taken,
   input  logic [XLEN-1:0]            branch_jump_target,
   output logic [XLEN-1:0]            instruction,
   output logic [XLEN-1:0]            pc_out,
   output logic [XLEN-1:0]            pc_plus_4,
   output logic                       valid
);

   ifu_state_t      r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_redirectPc;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_pcNext;
   logic            w_ifidLoad;
   logic            w_ifidBubble;
   logic [XLEN-1:0] w_ifidInstr;
`ifdef IFU_SKID_BUFFER_EN
   logic [XLEN-1:0] r_skidData;
   logic            r_skidFull;
`endif

   assign w_target = alignWord(branch_jump_target);
   assign w_pcNext = r_pc + XLEN'(4);

   // The read strobe is the only unregistered output; gating it with reset
   // drops an in-flight request the moment reset asserts.
   assign imem.i_mem_read    = reset & (r_state != HOLD);
   assign imem.i_mem_address = r_pc;

   // IF/ID control. Whenever decode accepts (no stall) the register must be
   // overwritten, either with a fresh word or with a bubble, so nothing is
   // consumed twice. A redirect squashes whatever fetch is delivering.
   always_comb begin
      w_ifidLoad   = 1'b0;
      w_ifidBubble = 1'b0;
      w_ifidInstr  = imem.i_mem_readdata;
      case (r_state)
         FETCH: begin
            if (branch_jump_taken || (!stall && imem.i_mem_busy)) begin
               w_ifidBubble = 1'b1;
            end else if (!stall) begin
               w_ifidLoad = 1'b1;
            end
         end
         HOLD: begin
            if (branch_jump_taken) begin
               w_ifidBubble = 1'b1;
            end else if (!stall) begin
`ifdef IFU_SKID_BUFFER_EN
               if (r_skidFull) begin
                  w_ifidLoad  = 1'b1;
                  w_ifidInstr = r_skidData;
               end else begin
                  w_ifidBubble = 1'b1;
               end
`else
               w_ifidBubble = 1'b1;
`endif
            end
         end
         default: begin
            w_ifidBubble = 1'b1;
         end
      endcase
   end

   // Fetch state machine. FLUSH exists because a busy request cannot be
   // withdrawn: the stale read is allowed to finish and its data dropped,
   // then the most recent redirect target is issued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= FETCH;
         r_pc         <= RESET_PC;
         r_redirectPc <= '0;
`ifdef IFU_SKID_BUFFER_EN
         r_skidData   <= '0;
         r_skidFull   <= 1'b0;
`endif
      end else begin
         case (r_state)
            FETCH: begin
               if (branch_jump_taken) begin
                  if (imem.i_mem_busy) begin
                     r_redirectPc <= w_target;
                     r_state      <= FLUSH;
                  end else begin
                     r_pc <= w_target;
                  end
               end else if (stall) begin
                  if (!imem.i_mem_busy) begin
                     r_state <= HOLD;
`ifdef IFU_SKID_BUFFER_EN
                     r_skidData <= imem.i_mem_readdata;
                     r_skidFull <= 1'b1;
`endif
                  end
               end else if (!imem.i_mem_busy) begin
                  r_pc <= w_pcNext;
               end
            end
            HOLD: begin
               if (branch_jump_taken) begin
                  r_pc    <= w_target;
                  r_state <= FETCH;
`ifdef IFU_SKID_BUFFER_EN
                  r_skidFull <= 1'b0;
`endif
               end else if (!stall) begin
                  r_state <= FETCH;
`ifdef IFU_SKID_BUFFER_EN
                  if (r_skidFull) begin
                     r_pc <= w_pcNext;
                  end
                  r_skidFull <= 1'b0;
`endif
               end
            end
            FLUSH: begin
               if (!imem.i_mem_busy) begin
                  r_pc    <= branch_jump_taken ? w_target : r_redirectPc;
                  r_state <= FETCH;
               end else if (branch_jump_taken) begin
                  r_redirectPc <= w_target;
               end
            end
            default: begin
               r_state <= FETCH;
            end
         endcase
      end
   end

   if_id_register u_ifId (
      .clk           (clk),
      .reset         (reset),
      .i_load        (w_ifidLoad),
      .i_bubble      (w_ifidBubble),
      .i_instruction (w_ifidInstr),
      .i_pc          (r_pc),
      .o_instruction (instruction),
      .o_pc          (pc_out),
      .o_pcPlus4     (pc_plus_4),
      .o_valid       (valid)
   );

endmodule
